fifo_stream_reader: RTL and testbench

- Consumer-side adapter for the fifoIf reader modport.
- Drives rd_en and captures rd_data from a synchronous-read FIFO, where data is valid one cycle after an accepted rd_en.
- Presents the words as a valid/ready stream with zero bubbles at full throughput.
- A 2-entry output buffer absorbs the one-cycle read latency and stream back-pressure; sits between any fifoIf-based FIFO and a downstream pipeline stage.

---
 rtl/fifo_stream_reader_pkg.sv | 16 +
 rtl/fifo_stream_reader_if.sv | 23 ++
 rtl/fifo_stream_reader.sv | 92 +++++++++
 tb/tb_fifo_stream_reader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and read-issue rule for the FIFO-to-stream reader.
// The can_issue rule is the single definition of when a new FIFO read may start.
package fifo_stream_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] buf_cnt_t;

  // A read may start if the word can land in a free slot, counting one that frees up this cycle.
  function automatic logic can_issue(input buf_cnt_t count, input logic inflight, input logic pop);
    logic [2:0] occ;
    occ = {1'b0, count} + {2'b00, inflight};
    return (occ < 3'd2) || ((occ == 3'd2) && pop);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifoIf: synchronous-read FIFO port (reader/source sides); stream_if: valid/ready word stream.
// Both are parameterised on the word width.
interface fifoIf #(
  parameter int DATA_WIDTH = 32
);
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;

  modport reader (output rd_en, input rd_data, input empty);
  modport source (input rd_en, output rd_data, output empty);
endinterface

interface stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// Sync-read FIFO to valid/ready stream: out_valid 2 cycles after rd_en, 1 word/cycle sustained, 2-entry buffer stalls rd_en under backpressure.
// FIFO_STREAM_READER_FLUSH_EN adds a synchronous flush input that empties the buffer and drops any in-flight word.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2
) (
  input  logic     clk,
  input  logic     rst,
`ifdef FIFO_STREAM_READER_FLUSH_EN
  input  logic     flush,
`endif
  fifoIf.reader    fifo,
  stream_if.master out,
  output buf_cnt_t buf_count
);

  if (BUF_DEPTH != fifo_stream_pkg::BUF_DEPTH) begin : g_depth_chk
    $error("fifo_stream_reader: BUF_DEPTH must be 2");
  end

  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  buf_cnt_t              r_count;
  logic                  r_inflight;

  logic w_flush;
  logic w_out_valid;
  logic w_pop;
  logic w_push;
  logic w_rd_en;

`ifdef FIFO_STREAM_READER_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_out_valid = (r_count != 2'd0) && !w_flush;
  assign w_pop       = w_out_valid && out.out_ready;
  assign w_push      = r_inflight;
  assign w_rd_en     = !rst && !fifo.empty && !w_flush && can_issue(r_count, r_inflight, w_pop);

  assign fifo.rd_en    = w_rd_en;
  assign out.out_valid = w_out_valid;
  assign out.out_data  = r_buf0;
  assign buf_count     = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else if (w_flush) begin
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      case ({w_push, w_pop})
        2'b10: begin
          r_count <= r_count + 2'd1;
          if (r_count == 2'd0) r_buf0 <= fifo.rd_data;
          else                 r_buf1 <= fifo.rd_data;
        end
        2'b01: begin
          r_count <= r_count - 2'd1;
          r_buf0  <= r_buf1;
        end
        2'b11: begin
          // Count is unchanged; the arriving word goes behind whatever remains.
          if (r_count == 2'd1) begin
            r_buf0 <= fifo.rd_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo.rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  a_occupancy: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, r_count} + {2'b00, r_inflight}) <= 3'd2));

  a_no_read_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(w_rd_en && fifo.empty));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised scoreboard bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT,
// every loaded word is expected at the stream output in order, checked by a negedge monitor.
module tb_fifo_stream_reader;
  import fifo_stream_pkg::*;

  localparam int DW = 32;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  buf_cnt_t buf_count;
  logic     flush_now;

  fifoIf    #(.DATA_WIDTH(DW)) f_if ();
  stream_if #(.DATA_WIDTH(DW)) s_if ();

`ifdef FIFO_STREAM_READER_FLUSH_EN
  logic flush = 1'b0;
  assign flush_now = flush;
  fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fifo(f_if.reader), .out(s_if.master), .buf_count(buf_count));
`else
  assign flush_now = 1'b0;
  fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .fifo(f_if.reader), .out(s_if.master), .buf_count(buf_count));
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  logic          hold_empty = 1'b0;
  logic          m_take;
  logic [DW-1:0] m_word;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  // FIFO model: synchronous read, data presented one cycle after an accepted rd_en.
  initial begin
    f_if.empty     = 1'b1;
    f_if.rd_data   = '0;
    s_if.out_ready = 1'b0;
  end

  always begin
    @(posedge clk);
    m_take = f_if.rd_en && !f_if.empty;
    if (m_take) begin
      if (fifo_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fifo_underflow: rd_en accepted with model queue empty at %0t", $time);
        m_word = '0;
      end else begin
        m_word = fifo_q.pop_front();
      end
    end else begin
      m_word = $urandom;
    end
    #1;
    f_if.rd_data = m_word;
    #1;
    f_if.empty = (fifo_q.size() == 0) || hold_empty;
  end

  // Monitor: compares every accepted stream word against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      chk("rd_en_while_empty", {31'd0, f_if.rd_en && f_if.empty}, 0);
      chk("buf_count_max", {31'd0, buf_count > 2'd2}, 0);
      if (prev_hold && !flush_now) begin
        chk("hold_valid", {31'd0, s_if.out_valid}, 1);
        chk("hold_data", s_if.out_data, prev_data);
      end
      if (s_if.out_valid && s_if.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", s_if.out_data, $time);
        end else begin
          chk("stream_data", s_if.out_data, exp_q.pop_front());
        end
      end
      prev_hold = s_if.out_valid && !s_if.out_ready;
      prev_data = s_if.out_data;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time budget, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] t1 [3];
    int pushed;
    int n;
    t1[0] = 32'h11; t1[1] = 32'h22; t1[2] = 32'h33;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, s_if.out_valid}, 0);
    chk("rst_buf_count", {30'd0, buf_count}, 0);
    chk("rst_rd_en", {31'd0, f_if.rd_en}, 0);
    chk("rst_out_data", s_if.out_data, 0);

    // Three preloaded words: rd_en cycles 0..2, data on cycles 2..4
    for (int i = 0; i < 3; i++) push_word(t1[i]);
    s_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t1_rd_en", {31'd0, f_if.rd_en}, {31'd0, k <= 2});
      chk("t1_out_valid", {31'd0, s_if.out_valid}, {31'd0, (k >= 2) && (k <= 4)});
      if (k >= 2 && k <= 4) chk("t1_out_data", s_if.out_data, t1[k-2]);
    end
    chk("t1_buf_count_end", {30'd0, buf_count}, 0);

    // 16 words back to back with no bubbles
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) push_word(i);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_if.out_valid && n < 20);
    chk("t2_first_valid", {31'd0, s_if.out_valid}, 1);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("t2_no_bubble", {31'd0, s_if.out_valid}, 1);
    end
    @(negedge clk);
    chk("t2_valid_after", {31'd0, s_if.out_valid}, 0);
    wait_drain(50, "t2_drain");

    // Backpressure: buffer fills to 2 and reading stops
    @(posedge clk);
    #1;
    s_if.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'h100 + i);
    repeat (10) @(negedge clk);
    chk("t3_buf_count", {30'd0, buf_count}, 2);
    chk("t3_rd_en", {31'd0, f_if.rd_en}, 0);
    chk("t3_fifo_left", fifo_q.size(), 6);
    @(posedge clk);
    #1;
    s_if.out_ready = 1'b1;
    wait_drain(100, "t3_drain");

    // Random traffic, random empty gaps and random backpressure
    pushed = 0;
    n = 0;
    while ((pushed < 1000 || exp_q.size() != 0) && n < 20000) begin
      @(posedge clk);
      #1;
      if (pushed < 1000 && fifo_q.size() < 6 && ($urandom % 4) != 0) begin
        push_word($urandom);
        pushed++;
      end
      hold_empty     = (($urandom % 4) == 0);
      s_if.out_ready = $urandom % 2;
      n++;
    end
    @(posedge clk);
    #1;
    hold_empty     = 1'b0;
    s_if.out_ready = 1'b1;
    wait_drain(50, "t4_drain");
    chk("t4_all_pushed", pushed, 1000);

    // Asynchronous reset with a full buffer
    @(posedge clk);
    #1;
    s_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h200 + i);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_pre_count", {30'd0, buf_count}, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", {31'd0, s_if.out_valid}, 0);
    chk("t5_async_count", {30'd0, buf_count}, 0);
    chk("t5_async_rd_en", {31'd0, f_if.rd_en}, 0);
    chk("t5_async_data", s_if.out_data, 0);
    fifo_q.delete();
    exp_q.delete();
    push_word(32'hAB);
    s_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rd_en_c0", {31'd0, f_if.rd_en}, 1);
    @(negedge clk);
    chk("t5_valid_c1", {31'd0, s_if.out_valid}, 0);
    @(negedge clk);
    chk("t5_valid_c2", {31'd0, s_if.out_valid}, 1);
    chk("t5_data_c2", s_if.out_data, 32'hAB);
    wait_drain(20, "t5_drain");

`ifdef FIFO_STREAM_READER_FLUSH_EN
    // Flush with a full buffer discards everything held
    @(posedge clk);
    #1;
    s_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'h300 + i);
    repeat (6) @(posedge clk);
    #1;
    chk("t6_pre_count", {30'd0, buf_count}, 2);
    flush = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    push_word(32'h55);
    #1;
    chk("t6_flush_valid", {31'd0, s_if.out_valid}, 0);
    @(negedge clk);
    chk("t6_flush_rd_en", {31'd0, f_if.rd_en}, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("t6_count_after", {30'd0, buf_count}, 0);
    s_if.out_ready = 1'b1;
    wait_drain(20, "t6_drain");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
